norm_shift_pipe: RTL and testbench
==================================

NORM_SHIFT_PIPE -- requirements
Module: norm_shift_pipe

Interface
REQ-001 SHALL have parameter MANT_W, default 28, meaning the raw mantissa width (carry bit + hidden bit + 23 fraction + guard/round/sticky).
REQ-002 SHALL have parameter EXP_W, default 8, meaning the biased exponent width.
REQ-003 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst_n, input, 1, reset that is synchronous and active-low.
REQ-005 SHALL have port i_valid, input, 1, upstream data valid.
REQ-006 SHALL have port o_ready, output, 1, block can accept input this cycle.
REQ-007 SHALL have port i_sign, input, 1, result sign from the adder.
REQ-008 SHALL have port i_exp, input, EXP_W, pre-normalization biased exponent.
REQ-009 SHALL have port i_mant, input, MANT_W, raw adder sum; bit MANT_W-1 is carry-out.
REQ-010 SHALL have port o_valid, output, 1, output data valid.
REQ-011 SHALL have port i_ready, input, 1, downstream (rounder) accepts output.
REQ-012 SHALL have port o_sign, output, 1, passed-through sign.
REQ-013 SHALL have port o_exp, output, EXP_W, normalized exponent.
REQ-014 SHALL have port o_mant, output, MANT_W-1, normalized mantissa with hidden bit at MSB (unless subnormal/zero).
REQ-015 SHALL have ports o_zero, o_overflow, o_underflow, outputs, 1 each, result-class flags.

Function
REQ-016 SHALL be a 2-stage pipeline: S1 registers inputs plus leading-one position; S2 registers shifted mantissa, exponent and flags; latency exactly 2 cycles with no stall.
REQ-017 SHALL transfer on a handshake only when valid and ready are both high in the same cycle.
REQ-018 SHALL drive o_ready = ~S1_full | S1 advances this cycle; S1 advances when ~S2_full | i_ready.
REQ-019 SHALL hold S2 contents and o_valid stable while o_valid=1 and i_ready=0.
REQ-020 SHALL sustain one result per cycle when i_valid and i_ready stay high.
REQ-021 SHALL, when i_mant[MANT_W-1]=1, shift right by 1 with the dropped LSB ORed into the new bit 0 (sticky) and output exp = i_exp+1.
REQ-022 SHALL, in the REQ-021 case when i_exp+1 = 2^EXP_W-1, output exp all-ones, mantissa 0, o_overflow=1.
REQ-023 SHALL, when carry=0 and i_mant[MANT_W-2:0]=0, output exp 0, mantissa 0, o_zero=1, other flags 0.
REQ-024 SHALL otherwise compute lz = leading-zero count of i_mant[MANT_W-2:0] (0..MANT_W-2) in S1.
REQ-025 SHALL, if i_exp > lz, shift left by lz and output exp = i_exp - lz.
REQ-026 SHALL, if i_exp <= lz, shift left by max(i_exp-1, 0), output exp 0, o_underflow=1 (subnormal result).
REQ-027 SHALL pass i_sign unchanged; o_sign for a zero result equals the input sign.
REQ-028 SHALL keep at most one flag of o_zero/o_overflow/o_underflow high at a time.
REQ-029 SHALL not change outputs or state while i_valid=0 and the pipeline is empty.

Reset
REQ-030 SHALL, while i_rst_n=0 at a clock edge, clear both stage-valid bits so that o_valid=0, o_ready=1, o_exp=0, o_mant=0, o_sign=0 and all flags=0.
REQ-031 SHALL discard in-flight data when reset is asserted mid-operation; no result for it is produced after release.
REQ-032 SHALL accept input on the first edge after i_rst_n returns high.

Structure
REQ-033 SHALL take MANT_W, EXP_W, the all-ones exponent constant and an lz-count width typedef from shared package fp_add_pkg.
REQ-034 SHALL instantiate one sub-module, lopd_28bit: a tree of the existing 4-bit leading-one position cells plus a priority combine producing position and zero flag.
REQ-035 SHALL contain no combinational path from i_valid/i_mant to outputs; the only comb path is i_ready -> o_ready.

Verification
REQ-036 SHALL cover: i_mant=0x0800000 (bit23), i_exp=0x7F -> after 2 cycles o_mant=0x0800000<<3 MSB-aligned (hidden at bit26), o_exp=0x7C.
REQ-037 SHALL cover: i_mant=0xC000001, i_exp=0x80 -> o_exp=0x81, o_mant=0x6000001 (sticky kept), no flags.
REQ-038 SHALL cover: i_mant=0x8000000, i_exp=0xFE -> o_exp=0xFF, o_mant=0, o_overflow=1; and i_mant=0, i_exp=0x50 -> o_zero=1, o_exp=0.
REQ-039 SHALL cover: i_mant=0x0000010, i_exp=0x03 -> shift 2, o_exp=0, o_underflow=1.
REQ-040 SHALL cover: 8 back-to-back inputs with i_ready low on cycles 3-5 -> o_ready drops after both stages fill, outputs in order, none lost or duplicated.
REQ-041 SHALL cover: i_rst_n asserted with 2 items in flight -> o_valid=0 next cycle, no stale output after release.

Source files
------------

// File: rtl/norm_shift_pipe_pkg.sv
// Shared constants and types for the FP adder normalization path.
package fp_add_pkg;
  localparam int FP_MANT_W = 28;
  localparam int FP_EXP_W  = 8;
  localparam logic [FP_EXP_W-1:0] FP_EXP_ONES = '1;
  localparam int FP_LZ_W = $clog2(FP_MANT_W - 1);
  typedef logic [FP_LZ_W-1:0] lz_t;
endpackage

// File: rtl/norm_shift_pipe_if.sv
// Upstream (adder) and downstream (rounder) bundles of the normalizer.
interface norm_shift_pipe_if
  import fp_add_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W
);
  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              out_valid;
  logic              out_ready;
  logic              out_sign;
  logic [EXP_W-1:0]  out_exp;
  logic [MANT_W-2:0] out_mant;
  logic              out_zero;
  logic              out_ovf;
  logic              out_udf;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, out_ready,
    input  in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_ovf, out_udf
  );
  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, out_ready,
    output in_ready, out_valid, out_sign, out_exp, out_mant, out_zero, out_ovf, out_udf
  );
endinterface

// File: rtl/norm_shift_pipe_lopd.sv
// Leading-one position detector: 4-bit cells plus a nibble priority combine.
module lopd4 (
  input  logic [3:0] i_nib,
  output logic [1:0] o_pos,
  output logic       o_zero
);
  always_comb begin
    casez (i_nib)
      4'b1???: o_pos = 2'd0;
      4'b01??: o_pos = 2'd1;
      4'b001?: o_pos = 2'd2;
      default: o_pos = 2'd3;
    endcase
  end
  assign o_zero = ~|i_nib;
endmodule

module lopd_28bit #(
  parameter int W    = 27,
  parameter int LZ_W = 5
) (
  input  logic [W-1:0]    i_vec,
  output logic [LZ_W-1:0] o_lz,
  output logic            o_zero
);
  localparam int NIB  = (W + 3) / 4;
  localparam int PADW = NIB * 4;

  // Pad zeros below the LSB so the MSB nibble stays aligned with i_vec's MSB.
  logic [PADW-1:0]       w_pad;
  logic [NIB-1:0][1:0]   w_pos;
  logic [NIB-1:0]        w_nzero;

  assign w_pad = PADW'(i_vec) << (PADW - W);

  lopd4 u_cell [NIB-1:0] (
    .i_nib  (w_pad),
    .o_pos  (w_pos),
    .o_zero (w_nzero)
  );

  // Higher nibbles overwrite lower ones, so the most significant non-zero nibble wins.
  always_comb begin
    o_lz = '0;
    for (int k = 0; k < NIB; k++) begin
      if (!w_nzero[k]) o_lz = LZ_W'((NIB - 1 - k) * 4) + LZ_W'(w_pos[k]);
    end
  end
  assign o_zero = &w_nzero;
endmodule

// File: rtl/norm_shift_pipe.sv
// Two-stage post-add normalizer: S1 captures operands plus leading-zero count,
// S2 applies the shift, adjusts the exponent and classifies the result.
module norm_shift_pipe
  import fp_add_pkg::*;
#(
  parameter int MANT_W = FP_MANT_W,
  parameter int EXP_W  = FP_EXP_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic              i_sign,
  input  logic [EXP_W-1:0]  i_exp,
  input  logic [MANT_W-1:0] i_mant,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_sign,
  output logic [EXP_W-1:0]  o_exp,
  output logic [MANT_W-2:0] o_mant,
  output logic              o_zero,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam int LZ_W = $bits(lz_t);
  localparam logic [EXP_W-1:0] EXP_ONES = EXP_W'(FP_EXP_ONES);
  localparam logic [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
  localparam logic [EXP_W-1:0] EXP_PRE  = EXP_ONES - EXP_ONE;

  lz_t               w_lz;
  logic              w_lo_zero;
  logic              w_s1_adv;
  logic              w_in_fire;

  logic              r1_vld, r1_sign, r1_lo_zero;
  logic [EXP_W-1:0]  r1_exp;
  logic [MANT_W-1:0] r1_mant;
  lz_t               r1_lz;

  logic              r2_vld, r2_sign, r2_zero, r2_ovf, r2_udf;
  logic [EXP_W-1:0]  r2_exp;
  logic [MANT_W-2:0] r2_mant;

  logic [EXP_W-1:0]  w_lz_ext, w_sh, w_exp_n;
  logic [MANT_W-2:0] w_mant_n;
  logic              w_zero_n, w_ovf_n, w_udf_n;

  lopd_28bit #(.W(MANT_W - 1), .LZ_W(LZ_W)) u_lopd (
    .i_vec  (i_mant[MANT_W-2:0]),
    .o_lz   (w_lz),
    .o_zero (w_lo_zero)
  );

  assign w_s1_adv  = ~r2_vld | i_ready;
  assign o_ready   = ~r1_vld | w_s1_adv;
  assign w_in_fire = i_valid & o_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r1_vld     <= 1'b0;
      r1_sign    <= 1'b0;
      r1_exp     <= '0;
      r1_mant    <= '0;
      r1_lz      <= '0;
      r1_lo_zero <= 1'b0;
    end else if (w_in_fire) begin
      r1_vld     <= 1'b1;
      r1_sign    <= i_sign;
      r1_exp     <= i_exp;
      r1_mant    <= i_mant;
      r1_lz      <= w_lz;
      r1_lo_zero <= w_lo_zero;
    end else if (w_s1_adv) begin
      r1_vld     <= 1'b0;
    end
  end

  assign w_lz_ext = EXP_W'(r1_lz);

  always_comb begin
    w_exp_n  = '0;
    w_mant_n = '0;
    w_zero_n = 1'b0;
    w_ovf_n  = 1'b0;
    w_udf_n  = 1'b0;
    w_sh     = '0;
    if (r1_mant[MANT_W-1]) begin
      if (r1_exp >= EXP_PRE) begin
        w_exp_n = EXP_ONES;
        w_ovf_n = 1'b1;
      end else begin
        w_exp_n  = r1_exp + EXP_ONE;
        w_mant_n = {r1_mant[MANT_W-1:2], |r1_mant[1:0]};
      end
    end else if (r1_lo_zero) begin
      w_zero_n = 1'b1;
    end else if (r1_exp > w_lz_ext) begin
      w_mant_n = r1_mant[MANT_W-2:0] << r1_lz;
      w_exp_n  = r1_exp - w_lz_ext;
    end else begin
      // Subnormal: shift only until the exponent would reach 1, then encode as 0.
      w_sh     = (r1_exp == '0) ? '0 : r1_exp - EXP_ONE;
      w_mant_n = r1_mant[MANT_W-2:0] << w_sh;
      w_udf_n  = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r2_vld  <= 1'b0;
      r2_sign <= 1'b0;
      r2_exp  <= '0;
      r2_mant <= '0;
      r2_zero <= 1'b0;
      r2_ovf  <= 1'b0;
      r2_udf  <= 1'b0;
    end else if (w_s1_adv) begin
      r2_vld <= r1_vld;
      if (r1_vld) begin
        r2_sign <= r1_sign;
        r2_exp  <= w_exp_n;
        r2_mant <= w_mant_n;
        r2_zero <= w_zero_n;
        r2_ovf  <= w_ovf_n;
        r2_udf  <= w_udf_n;
      end
    end
  end

  assign o_valid     = r2_vld;
  assign o_sign      = r2_sign;
  assign o_exp       = r2_exp;
  assign o_mant      = r2_mant;
  assign o_zero      = r2_zero;
  assign o_overflow  = r2_ovf;
  assign o_underflow = r2_udf;
endmodule

// File: tb/tb_norm_shift_pipe.sv
// Self-checking bench for norm_shift_pipe: directed corner cases plus a
// randomized handshake run scored against an arithmetic reference model.
module tb_norm_shift_pipe;
  localparam int MW = 28;
  localparam int EW = 8;

  typedef struct packed {
    logic          sign;
    logic [EW-1:0] exp;
    logic [MW-2:0] mant;
    logic          zero;
    logic          ovf;
    logic          udf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   fails = 0;
  res_t exp_q[$];

  always #5 clk = ~clk;

  norm_shift_pipe_if #(.MANT_W(MW), .EXP_W(EW)) bus ();

  norm_shift_pipe #(.MANT_W(MW), .EXP_W(EW)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_valid     (bus.in_valid),
    .o_ready     (bus.in_ready),
    .i_sign      (bus.in_sign),
    .i_exp       (bus.in_exp),
    .i_mant      (bus.in_mant),
    .o_valid     (bus.out_valid),
    .i_ready     (bus.out_ready),
    .o_sign      (bus.out_sign),
    .o_exp       (bus.out_exp),
    .o_mant      (bus.out_mant),
    .o_zero      (bus.out_zero),
    .o_overflow  (bus.out_ovf),
    .o_underflow (bus.out_udf)
  );

  // Reference: normalize by counting leading zeros with integer arithmetic.
  function automatic res_t model(input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m);
    res_t r;
    int lz, sh;
    logic [MW-2:0] low;
    r = '0;
    r.sign = s;
    low = m[MW-2:0];
    if (m[MW-1]) begin
      if (int'(e) + 1 == 255) begin
        r.exp = 8'hFF;
        r.ovf = 1'b1;
      end else begin
        r.exp  = 8'(int'(e) + 1);
        r.mant = 27'(m / 2) | 27'(m % 2);
      end
    end else if (low == 0) begin
      r.zero = 1'b1;
    end else begin
      lz = 0;
      for (int i = 0; i < MW - 1; i++) if (low[i]) lz = (MW - 2) - i;
      if (int'(e) > lz) begin
        r.mant = low << lz;
        r.exp  = 8'(int'(e) - lz);
      end else begin
        sh = (e == 0) ? 0 : int'(e) - 1;
        r.mant = low << sh;
        r.udf  = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic res_t observed();
    res_t r;
    r.sign = bus.out_sign;
    r.exp  = bus.out_exp;
    r.mant = bus.out_mant;
    r.zero = bus.out_zero;
    r.ovf  = bus.out_ovf;
    r.udf  = bus.out_udf;
    return r;
  endfunction

  function automatic logic [MW-1:0] rand_mant();
    logic [MW-1:0] m;
    m = MW'($urandom);
    case ($urandom_range(0, 4))
      0: m[MW-1] = 1'b1;
      1: m = '0;
      2: m = MW'(1) << $urandom_range(0, MW - 2);
      3: m = (m >> $urandom_range(0, MW - 1)) & ~(MW'(1) << (MW - 1));
      default: ;
    endcase
    return m;
  endfunction

  function automatic logic [EW-1:0] rand_exp();
    case ($urandom_range(0, 3))
      0: return EW'($urandom_range(0, 6));
      1: return 8'hFE;
      default: return EW'($urandom_range(0, 254));
    endcase
  endfunction

  // One clock of stimulus; reports what was accepted and what left the pipe.
  task automatic cycle(input logic v, input logic s, input logic [EW-1:0] e, input logic [MW-1:0] m,
                       input logic rdy, output logic acc, output logic popped,
                       output logic had_exp, output res_t got, output res_t want);
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sign = s;
    bus.in_exp = e;
    bus.in_mant = m;
    bus.out_ready = rdy;
    #1;
    popped = bus.out_valid && rdy;
    got = observed();
    want = '0;
    had_exp = 1'b0;
    if (popped && exp_q.size() > 0) begin
      want = exp_q.pop_front();
      had_exp = 1'b1;
    end
    acc = v && bus.in_ready;
    if (acc) exp_q.push_back(model(s, e, m));
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_sign = 1'b0;
    bus.in_exp = '0;
    bus.in_mant = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_o_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_o_ready got=%b want=1", bus.in_ready); end
    checks++;
    if (observed() !== res_t'('0)) begin fails++; $display("FAIL reset_outputs got=%h want=0", observed()); end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic          vs[5];
    logic [EW-1:0] ve[5];
    logic [MW-1:0] vm[5];
    res_t          vr[5];
    vs[0] = 0; ve[0] = 8'h7F; vm[0] = 28'h0800000; vr[0] = {1'b0, 8'h7C, 27'h4000000, 3'b000};
    vs[1] = 0; ve[1] = 8'h80; vm[1] = 28'hC000001; vr[1] = {1'b0, 8'h81, 27'h6000001, 3'b000};
    vs[2] = 1; ve[2] = 8'hFE; vm[2] = 28'h8000000; vr[2] = {1'b1, 8'hFF, 27'h0, 3'b010};
    vs[3] = 1; ve[3] = 8'h50; vm[3] = 28'h0000000; vr[3] = {1'b1, 8'h00, 27'h0, 3'b100};
    vs[4] = 0; ve[4] = 8'h03; vm[4] = 28'h0000010; vr[4] = {1'b0, 8'h00, 27'h0000040, 3'b001};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_sign = vs[i];
      bus.in_exp = ve[i];
      bus.in_mant = vm[i];
      bus.out_ready = 1'b1;
      @(negedge clk);
      idle_inputs();
      #1;
      checks++;
      if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL dir%0d_early_valid got=%b want=0", i, bus.out_valid); end
      @(negedge clk);
      #1;
      checks++;
      if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL dir%0d_latency got=%b want=1", i, bus.out_valid); end
      checks++;
      if (observed() !== vr[i]) begin fails++; $display("FAIL dir%0d_result got=%h want=%h", i, observed(), vr[i]); end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, popped, had;
    res_t got, want;
    int idx, outs;
    logic stalled;
    logic          s[8];
    logic [EW-1:0] e[8];
    logic [MW-1:0] m[8];
    for (int i = 0; i < 8; i++) begin s[i] = 1'($urandom); e[i] = rand_exp(); m[i] = rand_mant(); end
    exp_q.delete();
    idx = 0; outs = 0; stalled = 1'b0;
    for (int c = 1; c <= 60 && outs < 8; c++) begin
      if (idx < 8) cycle(1'b1, s[idx], e[idx], m[idx], !(c >= 3 && c <= 5), acc, popped, had, got, want);
      else cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, popped, had, got, want);
      if (idx < 8 && !acc) stalled = 1'b1;
      if (acc) idx++;
      if (popped) begin
        outs++;
        checks++;
        if (!had || got !== want) begin fails++; $display("FAIL b2b_out%0d got=%h want=%h had=%b", outs, got, want, had); end
      end
    end
    checks++;
    if (outs !== 8) begin fails++; $display("FAIL b2b_count got=%0d want=8", outs); end
    checks++;
    if (stalled !== 1'b1) begin fails++; $display("FAIL b2b_ready_drop got=%b want=1", stalled); end
  endtask

  task automatic test_random();
    logic acc, popped, had;
    res_t got, want;
    for (int c = 0; c < 600; c++) begin
      cycle($urandom_range(0, 9) < 7, 1'($urandom), rand_exp(), rand_mant(), $urandom_range(0, 9) < 6,
            acc, popped, had, got, want);
      if (popped) begin
        checks++;
        if (!had || got !== want) begin fails++; $display("FAIL rand_c%0d got=%h want=%h had=%b", c, got, want, had); end
      end
    end
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, popped, had, got, want);
      if (popped) begin
        checks++;
        if (!had || got !== want) begin fails++; $display("FAIL rand_drain%0d got=%h want=%h", c, got, want); end
      end
    end
    checks++;
    if (exp_q.size() !== 0) begin fails++; $display("FAIL rand_lost got=%0d want=0", exp_q.size()); end
  endtask

  task automatic test_reset_inflight();
    logic acc, popped, had;
    res_t got, want;
    int outs;
    logic [EW-1:0] ne;
    logic [MW-1:0] nm;
    exp_q.delete();
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 8'h90, 28'h0123456, 1'b0, acc, popped, had, got, want);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL rstmid_o_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL rstmid_o_ready got=%b want=1", bus.in_ready); end
    exp_q.delete();
    ne = 8'h40;
    nm = 28'h0000F00;
    rst_n = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_sign = 1'b0;
    bus.in_exp = ne;
    bus.in_mant = nm;
    bus.out_ready = 1'b1;
    exp_q.push_back(model(1'b0, ne, nm));
    outs = 0;
    for (int c = 0; c < 8; c++) begin
      cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, popped, had, got, want);
      if (popped) begin
        outs++;
        checks++;
        if (!had || got !== want) begin fails++; $display("FAIL rstmid_out got=%h want=%h had=%b", got, want, had); end
      end
    end
    checks++;
    if (outs !== 1) begin fails++; $display("FAIL rstmid_count got=%0d want=1", outs); end
  endtask

  initial begin
    idle_inputs();
    bus.out_ready = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
